encoder_hall_monitor: RTL
=========================

ENCODER_HALL_MONITOR -- requirements
Module: encoder_hall_monitor

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 5, number of monitored motor channels.
REQ-002 SHALL have parameter ENCODER_COUNTER_WIDTH, default 15, per-channel signed encoder delta width.
REQ-003 SHALL have parameter HALL_COUNTER_WIDTH, default 8, per-channel signed hall delta width.
REQ-004 SHALL have parameter ENC_MIN, default 2, encoder magnitude strictly below which encoder counts as stalled.
REQ-005 SHALL have parameter HALL_MIN, default 2, hall magnitude at or above which the motor counts as turning.
REQ-006 SHALL have parameter STRIKE_LIMIT, default 3, consecutive bad samples needed to latch a fault (range 1..255).
REQ-007 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port sample, input, 1, one-cycle strobe marking valid count inputs.
REQ-010 SHALL have port enc_count, input, NUM_CHANNELS*ENCODER_COUNTER_WIDTH, channel i at bits [i*ENCODER_COUNTER_WIDTH +: ENCODER_COUNTER_WIDTH], two's complement.
REQ-011 SHALL have port hall_count, input, NUM_CHANNELS*HALL_COUNTER_WIDTH, same packing, two's complement.
REQ-012 SHALL have port chan_enable, input, NUM_CHANNELS, per-channel monitor enable.
REQ-013 SHALL have port fault_clear, input, NUM_CHANNELS, per-channel sticky-fault clear, level-sampled.
REQ-014 SHALL have port fault, output, NUM_CHANNELS, per-channel latched fault.
REQ-015 SHALL have port fault_code, output, 2*NUM_CHANNELS, per-channel cause: 0 none, 1 stall, 2 direction, 3 reserved.
REQ-016 SHALL have port fault_any, output, 1, registered OR of fault.

Function
REQ-017 SHALL compute magnitudes as unsigned two's-complement negation within the input width; most-negative input yields 2^(W-1), no saturation.
REQ-018 SHALL flag stall on a sample when |hall| >= HALL_MIN and |enc| < ENC_MIN.
REQ-019 SHALL flag direction when |hall| >= HALL_MIN, |enc| >= ENC_MIN and sign bits of enc and hall differ; stall takes precedence.
REQ-020 SHALL evaluate channels only in cycles with sample=1; with sample=0 all strike counters and states hold.
REQ-021 SHALL keep per-channel state machine OK / SUSPECT / FAULT with 8-bit strike counter.
REQ-022 SHALL, in OK or SUSPECT on a flagged sample, increment strike; go SUSPECT if new strike < STRIKE_LIMIT, else FAULT.
REQ-023 SHALL, in OK or SUSPECT on a clean sample, zero strike and go OK.
REQ-024 SHALL, on entering FAULT, assert fault[i] and load fault_code[i] with the cause of the final sample, in the cycle after the sample strobe (1-cycle latency).
REQ-025 SHALL hold FAULT, fault[i], fault_code[i] regardless of later samples until cleared.
REQ-026 SHALL, with fault_clear[i]=1 and no fault-entering sample on that channel in the same cycle, go OK, zero strike, deassert fault[i], set fault_code[i]=0 next cycle.
REQ-027 SHALL, if fault_clear[i] coincides with a sample that reaches STRIKE_LIMIT, let the fault win; clear in FAULT state with sample flagged re-arms to OK (strike 0).
REQ-028 SHALL, with chan_enable[i]=0, force channel to OK, strike 0, fault[i]=0, fault_code[i]=0 next cycle, ignoring samples.
REQ-029 SHALL saturate strike at STRIKE_LIMIT; no wrap.
REQ-030 SHALL register fault_any one cycle after fault changes.
REQ-031 SHALL process channels fully independently.

Reset
REQ-032 SHALL, while reset=0, asynchronously force all states OK, strikes 0, fault=0, fault_code=0, fault_any=0.
REQ-033 SHALL resume evaluation on the first rising clk edge after reset deasserts; reset mid-sequence discards partial strikes.

Verification
REQ-034 Ch0 hall=+5, enc=0, three sample strobes -> fault[0]=1, fault_code[0]=1 one cycle after third strobe; fault_any=1 one cycle later.
REQ-035 Ch1 hall=-4, enc=+100 for 3 samples -> fault[1]=1, fault_code[1]=2; other channels stay 0.
REQ-036 Ch2 two bad samples, one clean (hall=5, enc=40), two bad -> no fault; third bad -> fault.
REQ-037 enc=-16384 (15-bit), hall=+3 -> magnitude 16384, sign mismatch -> direction flagged, not stall.
REQ-038 Ch0 in FAULT, fault_clear[0]=1 alone -> fault[0]=0 next cycle; clear coincident with third bad sample from OK -> fault[0]=1.
REQ-039 Ch3 SUSPECT (strike 2), reset pulsed low between clk edges -> outputs 0 immediately; three further bad samples needed for fault.

Source files
------------

// File: rtl/encoder_hall_monitor.sv
// rtl/encoder_hall_monitor.sv - per-channel encoder vs hall consistency monitor with sticky faults
//
// Purpose: each channel compares an encoder delta against a hall-sensor delta
// on every sample strobe. A channel whose hall reports motion while the
// encoder does not (stall), or whose signs disagree (direction), collects
// strikes; STRIKE_LIMIT consecutive bad samples latch a fault and its cause.
//
// Ports:
//   clk         - sole clock, rising edge
//   reset       - asynchronous active-low reset
//   sample      - one-cycle strobe, count inputs valid
//   enc_count   - NUM_CHANNELS packed signed encoder deltas
//   hall_count  - NUM_CHANNELS packed signed hall deltas
//   chan_enable - per-channel monitor enable (0 forces channel idle)
//   fault_clear - per-channel level-sampled sticky-fault clear
//   fault       - per-channel latched fault
//   fault_code  - per-channel cause, 2 bits each: 0 none, 1 stall, 2 direction
//   fault_any   - registered OR of fault
module encoder_hall_monitor #(
  parameter int NUM_CHANNELS          = 5,
  parameter int ENCODER_COUNTER_WIDTH = 15,
  parameter int HALL_COUNTER_WIDTH    = 8,
  parameter int ENC_MIN               = 2,
  parameter int HALL_MIN              = 2,
  parameter int STRIKE_LIMIT          = 3
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            sample,
  input  logic [NUM_CHANNELS*ENCODER_COUNTER_WIDTH-1:0]   enc_count,
  input  logic [NUM_CHANNELS*HALL_COUNTER_WIDTH-1:0]      hall_count,
  input  logic [NUM_CHANNELS-1:0]                         chan_enable,
  input  logic [NUM_CHANNELS-1:0]                         fault_clear,
  output logic [NUM_CHANNELS-1:0]                         fault,
  output logic [2*NUM_CHANNELS-1:0]                       fault_code,
  output logic                                            fault_any
);

  localparam int EW = ENCODER_COUNTER_WIDTH;
  localparam int HW = HALL_COUNTER_WIDTH;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_SUSPECT = 2'd1;
  localparam logic [1:0] ST_FAULT   = 2'd2;

  localparam logic [1:0] CODE_NONE  = 2'd0;
  localparam logic [1:0] CODE_STALL = 2'd1;
  localparam logic [1:0] CODE_DIR   = 2'd2;

  localparam logic [EW-1:0] ENC_MIN_V  = EW'(ENC_MIN);
  localparam logic [HW-1:0] HALL_MIN_V = HW'(HALL_MIN);
  localparam logic [7:0]    LIMIT_V    = 8'(STRIKE_LIMIT);

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [EW-1:0] enc;
    logic [HW-1:0] hall;
    logic [EW-1:0] enc_mag;
    logic [HW-1:0] hall_mag;
    logic          stall;
    logic          dir;
    logic          flagged;
    logic [1:0]    cause;
    logic [7:0]    strike_inc;
    logic          enter_fault;

    logic [1:0]    state;
    logic [7:0]    strike;
    logic          flt;
    logic [1:0]    code;

    assign enc  = enc_count[i*EW +: EW];
    assign hall = hall_count[i*HW +: HW];

    // Magnitude wraps within the input width: the most-negative value maps to
    // 2^(W-1), which is still representable as an unsigned W-bit number.
    assign enc_mag  = enc[EW-1]  ? -enc  : enc;
    assign hall_mag = hall[HW-1] ? -hall : hall;

    always_comb begin
      stall       = (hall_mag >= HALL_MIN_V) && (enc_mag < ENC_MIN_V);
      dir         = (hall_mag >= HALL_MIN_V) && !stall && (enc[EW-1] != hall[HW-1]);
      flagged     = stall || dir;
      cause       = stall ? CODE_STALL : (dir ? CODE_DIR : CODE_NONE);
      strike_inc  = (strike >= LIMIT_V) ? LIMIT_V : strike + 8'd1;
      enter_fault = sample && flagged && (state != ST_FAULT) && (strike_inc >= LIMIT_V);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state  <= ST_OK;
        strike <= 8'd0;
        flt    <= 1'b0;
        code   <= CODE_NONE;
      end else if (!chan_enable[i]) begin
        state  <= ST_OK;
        strike <= 8'd0;
        flt    <= 1'b0;
        code   <= CODE_NONE;
      end else if (enter_fault) begin
        // A fault-entering sample beats a coincident clear.
        state  <= ST_FAULT;
        strike <= strike_inc;
        flt    <= 1'b1;
        code   <= cause;
      end else if (fault_clear[i]) begin
        state  <= ST_OK;
        strike <= 8'd0;
        flt    <= 1'b0;
        code   <= CODE_NONE;
      end else if (sample && (state != ST_FAULT)) begin
        if (flagged) begin
          state  <= ST_SUSPECT;
          strike <= strike_inc;
        end else begin
          state  <= ST_OK;
          strike <= 8'd0;
        end
      end
    end

    assign fault[i]          = flt;
    assign fault_code[2*i +: 2] = code;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_any <= 1'b0;
    end else begin
      fault_any <= |fault;
    end
  end

endmodule
